// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: FSM states, decoded
// instruction classes, ALU op codes, opcode/funct constants and the mux
// select encodings used on the datapath control outputs.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU,
    I_SUBU,
    I_SLL,
    I_JR,
    I_ORI,
    I_ANDI,
    I_LW,
    I_SW,
    I_BEQ,
    I_LUI,
    I_J,
    I_JAL,
    I_ILL
  } iclass_t;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_LUI = 3'b111;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // pc_src encodings
  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // wd_sel encodings
  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;

  // reg_dst encodings
  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  // alu_src_b encodings
  localparam logic [1:0] ASB_RT     = 2'd0;
  localparam logic [1:0] ASB_FOUR   = 2'd1;
  localparam logic [1:0] ASB_IMM    = 2'd2;
  localparam logic [1:0] ASB_IMM_SH = 2'd3;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction-class decode.
//   op    : IR[31:26]
//   funct : IR[5:0]
//   cls   : decoded instruction class (I_ILL for anything unsupported)
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    cls = I_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = I_ADDU;
          FN_SUBU: cls = I_SUBU;
          FN_SLL:  cls = I_SLL;
          FN_JR:   cls = I_JR;
          default: cls = I_ILL;
        endcase
      end
      OP_ORI:  cls = I_ORI;
      OP_ANDI: cls = I_ANDI;
      OP_LW:   cls = I_LW;
      OP_SW:   cls = I_SW;
      OP_BEQ:  cls = I_BEQ;
      OP_LUI:  cls = I_LUI;
      OP_J:    cls = I_J;
      OP_JAL:  cls = I_JAL;
      default: cls = I_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle processor controller (IDLE/FETCH/DECODE/EXEC/MEM/WB).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   op, funct         : IR[31:26], IR[5:0]; only looked at from DECODE on
//   zero, mem_ready   : ALU zero flag, shared-memory completion
//   mem_req/we/sel    : memory request, write enable, address select
//   pc_write/pc_src   : PC load and source select; ir_write loads IR
//   reg_write/reg_dst/wd_sel : register-file write controls
//   alu_src_a/alu_src_b/ext_op/alu_op : ALU operand and op controls
//   retire, illegal   : one-cycle status pulses
// All outputs are a pure function of state and inputs; IDLE drives zero,
// so asynchronous reset forces every output low immediately.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [2:0] alu_op,
  output logic       retire,
  output logic       illegal
);

  state_t  state, state_n;
  iclass_t cls;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_sel   = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PCSRC_PC4;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = RD_RT;
    wd_sel    = WD_ALUOUT;
    alu_src_a = 1'b0;
    alu_src_b = ASB_RT;
    ext_op    = 1'b0;
    alu_op    = ALU_AND;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state)
      S_IDLE: state_n = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = ASB_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PCSRC_PC4;
          state_n  = S_DECODE;
        end
      end

      S_DECODE: begin
        // ALU speculatively forms the branch target into ALUOut
        alu_src_b = ASB_IMM_SH;
        alu_op    = ALU_ADD;
        case (cls)
          I_J, I_JAL: begin
            pc_write = 1'b1;
            pc_src   = PCSRC_JUMP;
            retire   = 1'b1;
            state_n  = S_FETCH;
            if (cls == I_JAL) begin
              reg_write = 1'b1;
              reg_dst   = RD_R31;
              wd_sel    = WD_PC;
            end
          end
          I_JR: begin
            pc_write = 1'b1;
            pc_src   = PCSRC_RS;
            retire   = 1'b1;
            state_n  = S_FETCH;
          end
          I_ILL: begin
            illegal = 1'b1;
            state_n = S_FETCH;
          end
          default: state_n = S_EXEC;
        endcase
      end

      S_EXEC: begin
        state_n = S_WB;
        case (cls)
          I_ADDU: begin alu_op = ALU_ADD; alu_src_a = 1'b1; alu_src_b = ASB_RT; end
          I_SUBU: begin alu_op = ALU_SUB; alu_src_a = 1'b1; alu_src_b = ASB_RT; end
          I_SLL:  begin alu_op = ALU_SLL; alu_src_a = 1'b1; alu_src_b = ASB_RT; end
          I_ORI:  begin alu_op = ALU_OR;  alu_src_b = ASB_IMM; ext_op = 1'b1; end
          I_ANDI: begin alu_op = ALU_AND; alu_src_b = ASB_IMM; ext_op = 1'b1; end
          I_LUI:  begin alu_op = ALU_LUI; alu_src_b = ASB_IMM; end
          I_LW, I_SW: begin
            alu_op    = ALU_ADD;
            alu_src_a = 1'b1;
            alu_src_b = ASB_IMM;
            state_n   = S_MEM;
          end
          I_BEQ: begin
            alu_op    = ALU_SUB;
            alu_src_a = 1'b1;
            alu_src_b = ASB_RT;
            retire    = 1'b1;
            state_n   = S_FETCH;
            if (zero) begin
              pc_write = 1'b1;
              pc_src   = PCSRC_BRANCH;
            end
          end
          default: state_n = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (cls == I_SW);
        if (mem_ready) begin
          if (cls == I_LW) begin
            state_n = S_WB;
          end else begin
            retire  = 1'b1;
            state_n = S_FETCH;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        reg_dst   = (op == OP_RTYPE) ? RD_RD : RD_RT;
        wd_sel    = (cls == I_LW) ? WD_MDR : WD_ALUOUT;
        state_n   = S_FETCH;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a small reference model produces the
// expected control word each cycle (scoreboard queue), a vector table
// drives whole instructions and checks length/retire/illegal, and
// hand-written sequences cover reset in the middle of a memory wait.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_sel, pc_write, ir_write, reg_write;
  logic       alu_src_a, ext_op, retire, illegal;
  logic [1:0] pc_src, reg_dst, wd_sel, alu_src_b;
  logic [2:0] alu_op;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel(mem_sel), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .alu_op(alu_op), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, mem_sel, pc_write;
    logic [1:0] pc_src;
    logic       ir_write, reg_write;
    logic [1:0] reg_dst, wd_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [2:0] alu_op;
    logic       retire, illegal;
  } ctl_t;

  ctl_t act;
  assign act = {mem_req, mem_we, mem_sel, pc_write, pc_src, ir_write,
                reg_write, reg_dst, wd_sel, alu_src_a, alu_src_b, ext_op,
                alu_op, retire, illegal};

  typedef enum int {M_IDLE, M_FETCH, M_DECODE, M_EXEC, M_MEM, M_WB} mst_t;

  typedef struct {
    logic [5:0] op, funct;
    logic       zero;
    int         fw, mw, cyc, ret, ill;
  } vec_t;

  int   tests = 0, fails = 0;
  ctl_t sb[$];
  mst_t mstate = M_IDLE;
  vec_t vt[15];

  // Reference model of the controller, written directly from the
  // instruction table with literal encodings.
  function automatic void model(input mst_t s, input logic [5:0] o, f,
                                input logic z, r, output ctl_t e,
                                output mst_t ns);
    logic rt, addu, subu, sll, jr, ori, andi, lw, sw, beq, lui, j, jal, ill;
    rt   = (o == 6'b000000);
    addu = rt && f == 6'b100001;
    subu = rt && f == 6'b100011;
    sll  = rt && f == 6'b000000;
    jr   = rt && f == 6'b001000;
    ori  = o == 6'b001101;
    andi = o == 6'b001100;
    lw   = o == 6'b100011;
    sw   = o == 6'b101011;
    beq  = o == 6'b000100;
    lui  = o == 6'b001111;
    j    = o == 6'b000010;
    jal  = o == 6'b000011;
    ill  = !(addu || subu || sll || jr || ori || andi || lw || sw || beq ||
             lui || j || jal);
    e  = '0;
    ns = s;
    case (s)
      M_IDLE: ns = M_FETCH;
      M_FETCH: begin
        e.mem_req = 1; e.alu_src_b = 2'd1; e.alu_op = 3'b010;
        if (r) begin e.ir_write = 1; e.pc_write = 1; ns = M_DECODE; end
      end
      M_DECODE: begin
        e.alu_src_b = 2'd3; e.alu_op = 3'b010;
        if (j || jal) begin
          e.pc_write = 1; e.pc_src = 2'd2; e.retire = 1; ns = M_FETCH;
          if (jal) begin e.reg_write = 1; e.reg_dst = 2'd2; e.wd_sel = 2'd2; end
        end else if (jr) begin
          e.pc_write = 1; e.pc_src = 2'd3; e.retire = 1; ns = M_FETCH;
        end else if (ill) begin
          e.illegal = 1; ns = M_FETCH;
        end else ns = M_EXEC;
      end
      M_EXEC: begin
        ns = M_WB;
        if (addu) begin e.alu_op = 3'b010; e.alu_src_a = 1; end
        if (subu) begin e.alu_op = 3'b110; e.alu_src_a = 1; end
        if (sll)  begin e.alu_op = 3'b011; e.alu_src_a = 1; end
        if (ori)  begin e.alu_op = 3'b001; e.alu_src_b = 2'd2; e.ext_op = 1; end
        if (andi) begin e.alu_op = 3'b000; e.alu_src_b = 2'd2; e.ext_op = 1; end
        if (lui)  begin e.alu_op = 3'b111; e.alu_src_b = 2'd2; end
        if (lw || sw) begin
          e.alu_op = 3'b010; e.alu_src_a = 1; e.alu_src_b = 2'd2; ns = M_MEM;
        end
        if (beq) begin
          e.alu_op = 3'b110; e.alu_src_a = 1; e.retire = 1; ns = M_FETCH;
          if (z) begin e.pc_write = 1; e.pc_src = 2'd1; end
        end
      end
      M_MEM: begin
        e.mem_req = 1; e.mem_sel = 1; e.mem_we = sw;
        if (r) begin
          if (lw) ns = M_WB;
          else begin e.retire = 1; ns = M_FETCH; end
        end
      end
      M_WB: begin
        e.reg_write = 1; e.retire = 1;
        e.reg_dst = rt ? 2'd1 : 2'd0;
        e.wd_sel  = lw ? 2'd1 : 2'd0;
        ns = M_FETCH;
      end
      default: ns = M_IDLE;
    endcase
  endfunction

  task automatic check(input string nm, input ctl_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %06h expected %06h", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Called at posedge+1: drive, push expectation, compare at negedge,
  // then advance to the next posedge+1 and commit the model state.
  task automatic step(input logic [5:0] o, f, input logic z, r,
                      input string nm, output mst_t ns_out,
                      output logic ret_s, output logic ill_s);
    ctl_t e;
    mst_t ns;
    op = o; funct = f; zero = z; mem_ready = r;
    model(mstate, o, f, z, r, e, ns);
    sb.push_back(e);
    @(negedge clk);
    check(nm, sb.pop_front());
    ret_s = retire;
    ill_s = illegal;
    @(posedge clk);
    #1;
    mstate = ns;
    ns_out = ns;
  endtask

  task automatic run_instr(input vec_t v, input int idx);
    int   cyc = 0, nret = 0, nill = 0, fcnt = 0, mcnt = 0;
    logic done = 1'b0, r, rs, is;
    mst_t ns, cur;
    while (!done && cyc < 64) begin
      cur = mstate;
      r = 1'b0;
      if (cur == M_FETCH) begin
        r = (fcnt == v.fw);
        fcnt++;
        // IR contents are stale during fetch; outputs must not depend on them
        step(6'($urandom), 6'($urandom), 1'($urandom), r,
             $sformatf("v%0d_c%0d", idx, cyc), ns, rs, is);
      end else begin
        if (cur == M_MEM) begin r = (mcnt == v.mw); mcnt++; end
        step(v.op, v.funct, v.zero, r, $sformatf("v%0d_c%0d", idx, cyc),
             ns, rs, is);
      end
      cyc++;
      nret += int'(rs);
      nill += int'(is);
      if (cur != M_FETCH && ns == M_FETCH) done = 1'b1;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL v%0d_timeout: got %0d cycles without finishing, required completion", idx, cyc);
    end
    check_int($sformatf("v%0d_cycles", idx), cyc, v.cyc);
    check_int($sformatf("v%0d_retire", idx), nret, v.ret);
    check_int($sformatf("v%0d_illegal", idx), nill, v.ill);
  endtask

  initial begin
    mst_t ns;
    logic rs, is;
    //            op         funct      z  fw mw cyc ret ill
    vt[0]  = '{6'b000000, 6'b100001, 0, 0, 0, 4,  1, 0};  // addu
    vt[1]  = '{6'b100011, 6'b000000, 0, 3, 3, 11, 1, 0};  // lw, slow memory
    vt[2]  = '{6'b000100, 6'b000000, 1, 0, 0, 3,  1, 0};  // beq taken
    vt[3]  = '{6'b000100, 6'b000000, 0, 0, 0, 3,  1, 0};  // beq not taken
    vt[4]  = '{6'b000011, 6'b000000, 0, 0, 0, 2,  1, 0};  // jal
    vt[5]  = '{6'b111111, 6'b000000, 0, 0, 0, 2,  0, 1};  // bad opcode
    vt[6]  = '{6'b000000, 6'b100011, 0, 1, 0, 5,  1, 0};  // subu
    vt[7]  = '{6'b000000, 6'b000000, 0, 0, 0, 4,  1, 0};  // sll
    vt[8]  = '{6'b001101, 6'b010101, 0, 0, 0, 4,  1, 0};  // ori
    vt[9]  = '{6'b001100, 6'b000000, 0, 0, 0, 4,  1, 0};  // andi
    vt[10] = '{6'b001111, 6'b000000, 0, 0, 0, 4,  1, 0};  // lui
    vt[11] = '{6'b101011, 6'b000000, 0, 0, 2, 6,  1, 0};  // sw
    vt[12] = '{6'b000010, 6'b000000, 0, 0, 0, 2,  1, 0};  // j
    vt[13] = '{6'b000000, 6'b001000, 0, 2, 0, 4,  1, 0};  // jr
    vt[14] = '{6'b000000, 6'b111111, 0, 0, 0, 2,  0, 1};  // bad funct

    op = 6'b100011; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", '0);

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mstate = M_IDLE;
    step(6'($urandom), 6'($urandom), 1'($urandom), 1'b1, "idle", ns, rs, is);

    foreach (vt[i]) run_instr(vt[i], i);

    // sw stuck in a memory wait, then reset arrives
    step(6'b101011, '0, 1'b0, 1'b1, "rs_fetch", ns, rs, is);
    step(6'b101011, '0, 1'b0, 1'b0, "rs_decode", ns, rs, is);
    step(6'b101011, '0, 1'b0, 1'b0, "rs_exec", ns, rs, is);
    step(6'b101011, '0, 1'b0, 1'b0, "rs_mem0", ns, rs, is);
    step(6'b101011, '0, 1'b0, 1'b0, "rs_mem1", ns, rs, is);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", '0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold", '0);
    rst_n  = 1'b1;
    mstate = M_IDLE;
    step(6'b101011, '0, 1'b0, 1'b1, "rst_idle", ns, rs, is);
    step(6'b101011, '0, 1'b0, 1'b0, "rst_fetch", ns, rs, is);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have ports op and funct, input, 6 each, carrying IR[31:26] and IR[5:0] as held in the IR register.
REQ-004 SHALL have port zero, input, 1, the ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1, shared-memory completion for the current request.
REQ-006 SHALL have memory outputs mem_req (1), mem_we (1) and mem_sel (1; 0 = PC address, 1 = ALUOut address).
REQ-007 SHALL have PC/IR outputs pc_write (1), pc_src (2; 0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs) and ir_write (1).
REQ-008 SHALL have register-file outputs reg_write (1), reg_dst (2; 0 = rt, 1 = rd, 2 = r31) and wd_sel (2; 0 = ALUOut, 1 = MDR, 2 = PC).
REQ-009 SHALL have ALU outputs alu_src_a (1; 0 = PC, 1 = rs), alu_src_b (2; 0 = rt, 1 = const 4, 2 = ext imm, 3 = ext imm<<2), ext_op (1; 1 = zero-extend) and alu_op (3).
REQ-010 SHALL have status outputs retire (1, one-cycle pulse per completed instruction) and illegal (1, one-cycle pulse on an undecoded instruction).

Function
REQ-011 SHALL use states IDLE, FETCH, DECODE, EXEC, MEM, WB.
REQ-012 SHALL drive every output to 0 in any state or condition not explicitly listed.
REQ-013 SHALL leave IDLE for FETCH unconditionally one cycle after reset release.
REQ-014 SHALL in FETCH drive mem_req=1, mem_sel=0, mem_we=0, alu_src_a=0, alu_src_b=1, alu_op=010; on mem_ready drive ir_write=1, pc_write=1, pc_src=0 and go to DECODE; otherwise hold FETCH with identical outputs.
REQ-015 SHALL in DECODE drive alu_src_a=0, alu_src_b=3, alu_op=010 (branch target into ALUOut).
REQ-016 SHALL in DECODE, for j: pc_write=1, pc_src=2, retire=1, go to FETCH.
REQ-017 SHALL in DECODE, for jal: the j outputs plus reg_write=1, reg_dst=2, wd_sel=2.
REQ-018 SHALL in DECODE, for jr: pc_write=1, pc_src=3, retire=1, go to FETCH.
REQ-019 SHALL in DECODE, for an undecoded op/funct: illegal=1, no writes, go to FETCH.
REQ-020 SHALL in DECODE, for all other instructions, go to EXEC.
REQ-021 SHALL decode opcodes: R-type 000000 with funct addu 100001, subu 100011, sll 000000, jr 001000; ori 001101; andi 001100; lw 100011; sw 101011; beq 000100; lui 001111; j 000010; jal 000011.
REQ-022 SHALL in EXEC use alu_op and operands: addu 010, subu 110 and sll 011 with alu_src_a=1, alu_src_b=0; ori 001 and andi 000 with alu_src_b=2, ext_op=1; lui 111 with alu_src_b=2; lw/sw 010 with alu_src_a=1, alu_src_b=2, ext_op=0.
REQ-023 SHALL after EXEC go to WB for ALU instructions and to MEM for lw/sw.
REQ-024 SHALL in EXEC for beq drive alu_op=110, alu_src_a=1, alu_src_b=0; pc_write=1, pc_src=1 only when zero=1; retire=1; go to FETCH.
REQ-025 SHALL in MEM drive mem_req=1, mem_sel=1, mem_we=1 for sw only; hold until mem_ready.
REQ-026 SHALL on mem_ready in MEM: lw goes to WB; sw drives retire=1 and goes to FETCH.
REQ-027 SHALL in WB drive reg_write=1 and retire=1, then go to FETCH.
REQ-028 SHALL in WB use reg_dst=1 for R-type, else 0, and wd_sel=1 for lw, else 0.
REQ-029 SHALL hold mem_req, mem_we and mem_sel stable from assertion until the mem_ready cycle, with no upper bound on wait length.
REQ-030 SHALL make pc_write, ir_write and reg_write at most one cycle per state visit.
REQ-031 SHALL read op/funct only in DECODE, EXEC, MEM and WB.

Reset
REQ-032 SHALL on rst_n low force state IDLE immediately, including mid-wait in FETCH or MEM, abandoning any pending memory request.
REQ-033 SHALL hold all outputs at 0 while reset is asserted.

Structure
REQ-034 SHALL place the state enum, ALU op codes, opcode/funct constants and pc_src/wd_sel/reg_dst/alu_src_b encodings in shared package mc_pkg.
REQ-035 SHALL place the combinational op/funct-to-instruction-class decode in one sub-module, mc_decode.

Verification
REQ-036 SHALL cover addu (op 0, funct 100001) with mem_ready=1 each request: FETCH, DECODE, EXEC, WB, reg_write=1 in WB with reg_dst=1, retire once, 4 cycles total.
REQ-037 SHALL cover lw with mem_ready delayed 3 cycles in both FETCH and MEM: mem_req held stable, wd_sel=1 in WB, 11 cycles total.
REQ-038 SHALL cover beq with zero=1 (pc_write=1, pc_src=1) and with zero=0 (pc_write=0), both 3 cycles.
REQ-039 SHALL cover jal: DECODE has pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wd_sel=2; next state FETCH.
REQ-040 SHALL cover op 111111: illegal=1 in DECODE, reg_write, pc_write and mem_we all 0, return to FETCH.
REQ-041 SHALL cover rst_n low during a MEM wait of sw: outputs 0 at once; after release IDLE one cycle, then FETCH with mem_sel=0.
